hazard_fwd_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 59 +++++
 rtl/hazard_fwd_ctrl_md_busy_cnt.sv | 31 +++
 rtl/hazard_fwd_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and stage-record types for the MIPS hazard/forwarding controller.
package hazard_pkg;

  localparam logic [1:0] KIND_ALU  = 2'd0;
  localparam logic [1:0] KIND_PC8  = 2'd1;
  localparam logic [1:0] KIND_XALU = 2'd2;
  localparam logic [1:0] KIND_MEM  = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [2:0] FWD_D_PRE       = 3'd0;
  localparam logic [2:0] FWD_D_ALUOUT_M  = 3'd1;
  localparam logic [2:0] FWD_D_PC8_M     = 3'd2;
  localparam logic [2:0] FWD_D_XALUOUT_M = 3'd3;

  localparam logic [2:0] FWD_E_PRE       = 3'd0;
  localparam logic [2:0] FWD_E_ALUOUT_M  = 3'd1;
  localparam logic [2:0] FWD_E_WDATA     = 3'd2;
  localparam logic [2:0] FWD_E_PC8_M     = 3'd3;
  localparam logic [2:0] FWD_E_PC8_W     = 3'd4;
  localparam logic [2:0] FWD_E_XALUOUT_M = 3'd5;
  localparam logic [2:0] FWD_E_XALUOUT_W = 3'd6;

  localparam logic [1:0] FWD_M_PRE       = 2'd0;
  localparam logic [1:0] FWD_M_WDATA     = 2'd1;
  localparam logic [1:0] FWD_M_PC8_W     = 2'd2;
  localparam logic [1:0] FWD_M_XALUOUT_W = 2'd3;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [1:0] kind;
    logic       md_start;
    logic       md_is_div;
  } e_stage_t;

  // Later stages only keep what forwarding still looks at.
  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [1:0] kind;
  } m_stage_t;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] kind;
  } w_stage_t;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    tnew_dec = (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_md_busy_cnt.sv
// HI/LO unit occupancy: loads the op latency when a mult/div enters E, then counts down.
module md_busy_cnt
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (start)
      r_cnt <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    else if (r_cnt != '0)
      r_cnt <= r_cnt - CW'(1);
  end

  assign busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Stall and forward-select generation for the 5-stage MIPS pipeline (tags tracked for E/M/W).
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] dst_D,
  input  logic [1:0] tnew_D,
  input  logic [1:0] kind_D,
  input  logic       md_start_D,
  input  logic       md_is_div_D,
  input  logic       hilo_use_D,
  output logic       stall,
  output logic [2:0] fwd_rs_D,
  output logic [2:0] fwd_rt_D,
  output logic [2:0] fwd_rs_E,
  output logic [2:0] fwd_rt_E,
  output logic [1:0] fwd_rt_M,
  output logic       md_busy
);

  e_stage_t r_e;
  m_stage_t r_m;
  w_stage_t r_w;
  e_stage_t w_d;
  logic     w_stall;

  assign w_d = '{rs: rs_D, rt: rt_D, dst: dst_D, tnew: tnew_D, kind: kind_D,
                 md_start: md_start_D, md_is_div: md_is_div_D};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_e <= w_stall ? '0 : w_d;
      r_m <= '{rt: r_e.rt, dst: r_e.dst, tnew: tnew_dec(r_e.tnew), kind: r_e.kind};
      r_w <= '{dst: r_m.dst, kind: r_m.kind};
    end
  end

  md_busy_cnt #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) u_md_busy_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (r_e.md_start),
    .is_div (r_e.md_is_div),
    .busy   (md_busy)
  );

  function automatic logic hazard(input logic [4:0] r, input logic [1:0] tuse);
    hazard = (r != 5'd0) && (tuse != TUSE_NONE) &&
             (((r_e.dst == r) && (r_e.tnew > tuse)) ||
              ((r_m.dst == r) && (r_m.tnew > tuse)));
  endfunction

  function automatic logic [2:0] sel_d(input logic [4:0] r);
    sel_d = FWD_D_PRE;
    if (r != 5'd0 && r_m.dst == r && r_m.tnew == 2'd0) begin
      case (r_m.kind)
        KIND_ALU:  sel_d = FWD_D_ALUOUT_M;
        KIND_PC8:  sel_d = FWD_D_PC8_M;
        KIND_XALU: sel_d = FWD_D_XALUOUT_M;
        default:   sel_d = FWD_D_PRE;
      endcase
    end
  endfunction

  // A matching but not-yet-ready M producer shadows W: nearest stage wins.
  function automatic logic [2:0] sel_e(input logic [4:0] r);
    sel_e = FWD_E_PRE;
    if (r != 5'd0 && r_m.dst == r) begin
      if (r_m.tnew == 2'd0) begin
        case (r_m.kind)
          KIND_ALU:  sel_e = FWD_E_ALUOUT_M;
          KIND_PC8:  sel_e = FWD_E_PC8_M;
          KIND_XALU: sel_e = FWD_E_XALUOUT_M;
          default:   sel_e = FWD_E_PRE;
        endcase
      end
    end else if (r != 5'd0 && r_w.dst == r) begin
      case (r_w.kind)
        KIND_PC8:  sel_e = FWD_E_PC8_W;
        KIND_XALU: sel_e = FWD_E_XALUOUT_W;
        default:   sel_e = FWD_E_WDATA;
      endcase
    end
  endfunction

  function automatic logic [1:0] sel_m(input logic [4:0] r);
    sel_m = FWD_M_PRE;
    if (r != 5'd0 && r_w.dst == r) begin
      case (r_w.kind)
        KIND_PC8:  sel_m = FWD_M_PC8_W;
        KIND_XALU: sel_m = FWD_M_XALUOUT_W;
        default:   sel_m = FWD_M_WDATA;
      endcase
    end
  endfunction

  assign w_stall = hazard(rs_D, tuse_rs_D) || hazard(rt_D, tuse_rt_D) ||
                   (hilo_use_D && (md_busy || r_e.md_start));
  assign stall    = w_stall;
  assign fwd_rs_D = sel_d(rs_D);
  assign fwd_rt_D = sel_d(rt_D);
  assign fwd_rs_E = sel_e(r_e.rs);
  assign fwd_rt_E = sel_e(r_e.rt);
  assign fwd_rt_M = sel_m(r_m.rt);

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: dependence, load-use, branch, jal, mult/div and reset cases.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_D, rt_D, dst_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D, kind_D;
  logic       md_start_D, md_is_div_D, hilo_use_D;
  logic       stall, md_busy;
  logic [2:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic [1:0] fwd_rt_M;

  int checks = 0;
  int errors = 0;

  hazard_fwd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rs_D(rs_D), .rt_D(rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .dst_D(dst_D),
    .tnew_D(tnew_D), .kind_D(kind_D), .md_start_D(md_start_D),
    .md_is_div_D(md_is_div_D), .hilo_use_D(hilo_use_D), .stall(stall),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E),
    .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [1:0] trs,
                       input logic [4:0] rt, input logic [1:0] trt,
                       input logic [4:0] dst, input logic [1:0] tnew,
                       input logic [1:0] kind, input logic md,
                       input logic dv, input logic hilo);
    rs_D = rs; tuse_rs_D = trs; rt_D = rt; tuse_rt_D = trt;
    dst_D = dst; tnew_D = tnew; kind_D = kind;
    md_start_D = md; md_is_div_D = dv; hilo_use_D = hilo;
    #1;
  endtask

  task automatic nop;
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // mult/div followed by mfhi, then an addu consuming the mfhi result.
  task automatic run_md(input logic dv, input int exp_stall, input int exp_busy, input string tag);
    int ns = 0;
    int nb = 0;
    set_d(5'd8, 2'd1, 5'd9, 2'd1, 5'd0, 2'd0, 2'd0, 1'b1, dv, 1'b1);
    chk({tag, "_issue_stall"}, stall, 0);
    tick;
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (!stall) break;
      ns++;
      if (md_busy) nb++;
      tick;
    end
    chk({tag, "_stall_cycles"}, ns, exp_stall);
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    chk({tag, "_busy_at_release"}, md_busy, 0);
    tick;
    set_d(5'd10, 2'd1, 5'd0, 2'd3, 5'd11, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_addu_no_stall"}, stall, 0);
    tick;
    nop;
    chk({tag, "_fwd_rs_E_xalu_m"}, fwd_rs_E, 5);
    tick;
    tick;
  endtask

  initial begin
    rst_n = 1'b0;
    nop;
    #11;
    chk("reset_stall", stall, 0);
    chk("reset_md_busy", md_busy, 0);
    chk("reset_fwd_D", {fwd_rs_D, fwd_rt_D}, 0);
    chk("reset_fwd_E", {fwd_rs_E, fwd_rt_E}, 0);
    chk("reset_fwd_M", fwd_rt_M, 0);
    rst_n = 1'b1;

    // addu $3 then subu using $3 in E
    tick;
    set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd3, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("addu_first_stall", stall, 0);
    tick;
    set_d(5'd3, 2'd1, 5'd0, 2'd3, 5'd6, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("b2b_stall", stall, 0);
    tick;
    nop;
    chk("b2b_fwd_rs_E", fwd_rs_E, 1);
    tick; tick;

    // lw $5 then addu reading $5
    set_d(5'd1, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0);
    tick;
    set_d(5'd0, 2'd3, 5'd5, 2'd1, 5'd7, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("loaduse_stall_1", stall, 1);
    tick;
    chk("loaduse_stall_2", stall, 0);
    tick;
    nop;
    chk("loaduse_fwd_rt_E", fwd_rt_E, 2);
    tick; tick;

    // addu $4 then beq on $4
    set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd4, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    tick;
    set_d(5'd4, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("beq_stall_1", stall, 1);
    tick;
    chk("beq_stall_2", stall, 0);
    chk("beq_fwd_rs_D", fwd_rs_D, 1);
    tick;
    nop;
    tick; tick;

    // jal then jr $31
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick;
    set_d(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("jr_stall_1", stall, 1);
    tick;
    chk("jr_stall_2", stall, 0);
    chk("jr_fwd_rs_D", fwd_rs_D, 2);
    tick;
    nop;
    tick; tick;

    // jal then sw $31
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick;
    set_d(5'd29, 2'd1, 5'd31, 2'd2, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("sw_stall", stall, 0);
    tick;
    nop;
    chk("sw_fwd_rt_E_pc8_m", fwd_rt_E, 3);
    tick;
    chk("sw_fwd_rt_M_pc8_w", fwd_rt_M, 2);
    tick; tick;

    run_md(1'b1, 11, 10, "div");
    run_md(1'b0, 6, 5, "mult");

    // producer with dst=0 followed by consumer of $0
    set_d(5'd1, 2'd1, 5'd0, 2'd3, 5'd0, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0);
    tick;
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd12, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("zero_stall", stall, 0);
    tick;
    nop;
    chk("zero_fwd_D", {fwd_rs_D, fwd_rt_D}, 0);
    chk("zero_fwd_E", {fwd_rs_E, fwd_rt_E}, 0);
    tick; tick;

    // reset asserted while a div is in flight
    set_d(5'd8, 2'd1, 5'd9, 2'd1, 5'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick;
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1);
    tick;
    chk("middiv_busy", md_busy, 1);
    chk("middiv_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_md_busy", md_busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fwd_all", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M}, 0);
    #10;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
